// File: rtl/div3_bit_serializer.sv
// rtl/div3_bit_serializer.sv - parallel-to-serial feeder for the divide-by-three checker
// Shifts accepted words out MSB-first and latches the checker verdict after each last bit.
module div3_bit_serializer #(
    parameter int WIDTH = 8,
    parameter int LEN_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic [LEN_W-1:0] in_len_i,
    output logic             x_o,
    output logic             x_valid_o,
    output logic             sof_o,
    output logic             eof_o,
    input  logic             div_i,
    output logic             result_valid_o,
    output logic             result_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);
    localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             first_q, first_d;
    logic             result_valid_q, result_valid_d;
    logic             result_q, result_d;

    logic             last_bit;
    logic             accept;
    logic [LEN_W-1:0] len_c;

    assign last_bit = (state_q == SHIFT) && (cnt_q == ONE_L);
    assign accept   = in_valid_i && in_ready_o;
    // Zero or oversize lengths mean a full-width word.
    assign len_c    = ((in_len_i == '0) || (in_len_i > WIDTH_L)) ? WIDTH_L : in_len_i;

    always_comb begin
        state_d        = state_q;
        shreg_d        = shreg_q;
        cnt_d          = cnt_q;
        first_d        = first_q;
        result_valid_d = 1'b0;
        result_d       = result_q;
        in_ready_o     = (state_q == IDLE) || last_bit;
        x_o            = 1'b0;
        x_valid_o      = 1'b0;
        sof_o          = 1'b0;
        eof_o          = 1'b0;

        if (state_q == SHIFT) begin
            x_o       = shreg_q[WIDTH-1];
            x_valid_o = 1'b1;
            sof_o     = first_q;
            eof_o     = last_bit;
            shreg_d   = shreg_q << 1;
            cnt_d     = cnt_q - ONE_L;
            first_d   = 1'b0;
            if (last_bit) begin
                state_d        = IDLE;
                result_valid_d = 1'b1;
                result_d       = div_i;
            end
        end

        // A reload on the last bit overrides the return to IDLE: no bubble between words.
        if (accept) begin
            state_d = SHIFT;
            shreg_d = in_data_i << (WIDTH_L - len_c);
            cnt_d   = len_c;
            first_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            shreg_q        <= '0;
            cnt_q          <= '0;
            first_q        <= 1'b0;
            result_valid_q <= 1'b0;
            result_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            shreg_q        <= shreg_d;
            cnt_q          <= cnt_d;
            first_q        <= first_d;
            result_valid_q <= result_valid_d;
            result_q       <= result_d;
        end
    end

    assign result_valid_o = result_valid_q;
    assign result_o       = result_q;

endmodule
